// File: rtl/cic_pkg.sv
// Shared constants for the CIC decimation path.
// Holds the controller state encoding and default geometry (ratio width,
// filter order). The integrator/comb datapath modules import the same
// package so every block agrees on the sequencing states.
package cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } cic_state_e;

    localparam int DEF_RATIO_W  = 16;
    localparam int DEF_N_STAGES = 4;

endpackage

// File: rtl/cic_rate_counter.sv
// Modulo-R decimation counter.
// Counts accepted samples 0 .. ratio-1. On the increment that hits ratio-1
// it wraps to 0 and registers a one-cycle terminal-count strobe, which
// appears the cycle after the accept (aligned with the registered
// integrator output).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of count and pending strobe
//   inc      : advance the counter (one accepted sample)
//   ratio    : modulus R (must be non-zero while counting)
//   count    : current count value
//   strobe   : registered terminal-count pulse
module cic_rate_counter #(
    parameter int RATIO_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [RATIO_W-1:0] ratio,
    output logic [RATIO_W-1:0] count,
    output logic               strobe
);

    logic term;

    assign term = (count == (ratio - RATIO_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            strobe <= 1'b0;
        end else if (clr) begin
            count  <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= inc && term;
            if (inc) begin
                count <= term ? '0 : count + RATIO_W'(1);
            end
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator control and sequencing.
// Latches the decimation ratio, flushes the integrator and comb chains on
// every reconfiguration, generates integrator enables and the comb
// decimation strobe, discards the first N_STAGES comb outputs while the
// comb delay lines fill, and drives a valid/ready output handshake with a
// sticky overrun flag. No datapath arithmetic lives here.
//
// Handshake: a sample is taken when in_valid & in_ready; a decimated word
// is consumed when out_valid & out_ready. The input side is never stalled
// by the output side: a new word arriving while the previous one is still
// unconsumed overwrites it and sets overrun.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cfg_ratio, cfg_load : ratio value and its one-cycle load pulse (0 = off)
//   cfg_busy            : high while flushing or warming up
//   in_valid, in_ready  : input sample handshake
//   integ_ce, integ_clr : integrator chain enable / synchronous clear
//   comb_ce, comb_clr   : comb chain enable (decimation strobe) / clear
//   out_valid, out_ready: output word handshake
//   overrun, ovr_clr    : sticky lost-word flag and its clear
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int RATIO_W  = DEF_RATIO_W,
    parameter int N_STAGES = DEF_N_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic               cfg_load,
    output logic               cfg_busy,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               integ_ce,
    output logic               integ_clr,
    output logic               comb_ce,
    output logic               comb_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overrun,
    input  logic               ovr_clr
);

    localparam int CNT_W = $clog2(N_STAGES + 1);
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(N_STAGES - 1);

    cic_state_e         state_q, state_d;
    logic [RATIO_W-1:0] ratio_q;
    logic [CNT_W-1:0]   flush_cnt;
    logic [CNT_W-1:0]   warm_cnt;
    logic [RATIO_W-1:0] dec_count;
    logic               accept;
    logic               ctr_clr;
    logic               out_valid_q;
    logic               overrun_q;
    logic               ovr_set;

    // ------------------------------------------------------------------
    // Next-state logic. A cfg_load overrides whatever the current state
    // would do, so reconfiguration always aborts cleanly.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_FLUSH:  if (flush_cnt == LAST_STAGE) state_d = ST_WARMUP;
            ST_WARMUP: if (comb_ce && (warm_cnt == LAST_STAGE)) state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
        if (cfg_load) begin
            state_d = (cfg_ratio != '0) ? ST_FLUSH : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Combinational outputs derived from state.
    // ------------------------------------------------------------------
    // The cycle carrying cfg_load never accepts a sample: the old ratio
    // and the counter are about to be discarded.
    assign in_ready  = ((state_q == ST_WARMUP) || (state_q == ST_RUN)) && !cfg_load;
    assign accept    = in_valid && in_ready;
    assign integ_ce  = accept;
    assign integ_clr = (state_q == ST_FLUSH);
    assign comb_clr  = (state_q == ST_FLUSH);
    assign cfg_busy  = (state_q == ST_FLUSH) || (state_q == ST_WARMUP);

    // ------------------------------------------------------------------
    // Ratio latch and flush / warm-up counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ratio_q   <= '0;
            flush_cnt <= '0;
            warm_cnt  <= '0;
        end else begin
            if (cfg_load) begin
                ratio_q <= cfg_ratio;
            end

            // Restarting FLUSH always begins a full-length count.
            if (cfg_load || (state_q != ST_FLUSH)) begin
                flush_cnt <= '0;
            end else begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end

            if (cfg_load || (state_q == ST_FLUSH)) begin
                warm_cnt <= '0;
            end else if ((state_q == ST_WARMUP) && comb_ce) begin
                warm_cnt <= warm_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Decimation counter; its registered strobe is the comb enable.
    // Clearing on cfg_load drops any strobe already pending.
    // ------------------------------------------------------------------
    assign ctr_clr = cfg_load || (state_q == ST_FLUSH);

    cic_rate_counter #(
        .RATIO_W (RATIO_W)
    ) u_rate_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (ctr_clr),
        .inc    (accept),
        .ratio  (ratio_q),
        .count  (dec_count),
        .strobe (comb_ce)
    );

    // ------------------------------------------------------------------
    // Output handshake and overrun.
    // A comb_ce in RUN marks a fresh word next cycle; it takes priority
    // over consumption so back-to-back words have no bubble.
    // ------------------------------------------------------------------
    assign ovr_set = comb_ce && out_valid_q && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (cfg_load || (state_q == ST_FLUSH)) begin
                out_valid_q <= 1'b0;
            end else if (comb_ce && (state_q == ST_RUN)) begin
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule
